relm_div_seq: RTL and testbench
===============================

# relm_div_seq

Multi-cycle restoring divider for the ReLM custom datapath. It moves the software-driven DIV/DIVLOOP and FDIV/FDIVLOOP quotient stepping into a self-timed unit. It is parametrised in word width and quotient bits per cycle, and supports an unsigned integer mode and a normalised-mantissa fraction mode that reports a sticky bit. It sits beside the combinational custom-op unit: the CPU issues a start and then collects quotient, remainder and flags on the done pulse.

## Interface
- `WD`, default 32: operand/result width.
- `STEP`, default 2: quotient bits retired per cycle. Legal values are 1, 2 and 4, and `STEP` must divide `WD`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_in`  in  1  request a division; sampled only when accepted.
- `mode_in`  in  1  0 = unsigned integer, 1 = fraction.
- `n_in`  in  WD  dividend, sampled with `start_in`.
- `d_in`  in  WD  divisor, sampled with `start_in`.
- `busy_out`  out  1  high while iterating.
- `done_out`  out  1  one-cycle pulse; results are valid in this cycle and afterwards.
- `q_out`  out  WD  quotient.
- `r_out`  out  WD  remainder.
- `sticky_out`  out  1  remainder nonzero.
- `dz_out`  out  1  divide-by-zero or illegal divisor.

## Operation
- States:
  - IDLE: go to RUN on accepted start, or to DONE on a zero/illegal divisor.
  - RUN: decrement the counter; go to DONE when the counter reaches 0.
  - DONE: go to RUN or DONE on an accepted start, else IDLE.
- Start acceptance: `start_in` is accepted in IDLE or DONE. It is ignored in RUN, with no effect and no queueing.
- Dividend setup: the dividend is a 2·WD-bit value split into a partial remainder P (upper WD bits) and a shift register S (lower WD bits).
  - Integer mode: P = 0, S = n.
  - Fraction mode: the dividend is n << (WD-1), so P = n >> 1 and S = {n[0], (WD-1)'b0}.
  - Precondition in both cases: P < d, so the quotient fits in WD bits.
- Per step (×STEP per RUN cycle):
  - T = {P, S[WD-1]} − {0, d}, computed in WD+1 bits.
  - If no borrow: P = T[WD-1:0] and quotient bit = 1. Otherwise P = {P[WD-2:0], S[WD-1]} and quotient bit = 0.
  - S shifts left one bit, taking the quotient bit into the LSB.
- Iteration count: ITER = WD/STEP RUN cycles, identical in both modes.
- Results on entry to DONE: q = S, r = P, sticky = |P, dz = 0.
- Zero/illegal divisor: in integer mode d = 0; in fraction mode d[WD-1] = 0 (which includes d = 0). The block does not iterate. It sets q = all ones, r = n, sticky = 1, dz = 1.
- Fraction mode with n[WD-1] = 0 is not flagged. The result is still arithmetically floor((n<<(WD-1))/d).
- Output registers (`q_out`, `r_out`, `sticky_out`, `dz_out`) change only on entry to DONE. They hold until the next DONE entry and are not disturbed during RUN.

## Timing
- Start sampled at edge 0 (normal divisor): RUN covers cycles 1..ITER; DONE with `done_out` = 1 falls in cycle ITER+1. Latency is ITER+1 (17 for 32/2).
- Divide-by-zero path: DONE in cycle 1, latency 1.
- `busy_out` = (state == RUN). `done_out` = (state == DONE), one cycle per result.
- Back-to-back: a start accepted in the DONE cycle begins the next operation immediately, giving a throughput of one result per ITER+1 cycles.
- Reset values: state IDLE, counter 0, and every output (`busy_out`, `done_out`, `q_out`, `r_out`, `sticky_out`, `dz_out`) = 0.
- Reset during RUN or DONE: abandon the operation. The next cycle is IDLE with all outputs 0 and no `done_out`.
- Reset has priority over a simultaneous start.

## Structure
- Package `relm_div_pkg` holds:
  - the state encoding (IDLE/RUN/DONE),
  - the mode constants (MODE_INT = 0, MODE_FRAC = 1),
  - ITER = WD/STEP,
  - the counter width ($clog2(ITER)+1).
- Sub-module `relm_div_step`: one combinational restoring step, parametrised by WD and mapping (P, S, d) → (P', S'). It is instantiated STEP times in a chain.
- The top level holds the FSM, counter, working registers and output registers.

## Test plan
- Integer, WD=32, STEP=2: n = 100, d = 7 → q = 14, r = 2, sticky = 1, dz = 0. `done_out` in cycle 17 after start; `busy_out` high in cycles 1–16.
- Integer divide by zero: n = 5, d = 0 → `done_out` in cycle 1, q = 0xFFFFFFFF, r = 5, sticky = 1, dz = 1. Fraction mode with d = 0x40000000 gives the same flags.
- Fraction, n = 0x80000000, d = 0xC0000000 → q = 0x55555555, r = 0x40000000, sticky = 1.
- Fraction, n = d = 0xC0000000 → q = 0x80000000, r = 0, sticky = 0.
- Start while busy:
  - Second start in cycle 3 is ignored and the first result is unchanged.
  - Start in the DONE cycle gives the next `done_out` exactly 17 cycles later.
  - Reset asserted in cycle 5 of RUN → IDLE next cycle with all outputs 0. A fresh 100/7 afterwards is correct.
- Parameter sweep at STEP = 1 and STEP = 4 (WD = 32), n = 0xFFFFFFFF, d = 1 → q = 0xFFFFFFFF, r = 0, with latency 33 and 9 respectively. Add a randomized integer and fraction comparison against a reference model.

Source files
------------

// File: rtl/relm_div_pkg.sv
// Shared types and sizing helpers for the ReLM sequential restoring divider.
package relm_div_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic MODE_INT  = 1'b0;
    localparam logic MODE_FRAC = 1'b1;

    // Number of RUN cycles for a given width and bits retired per cycle.
    function automatic int unsigned iter_of(int unsigned wd, int unsigned step);
        return wd / step;
    endfunction

    function automatic int unsigned cnt_width(int unsigned wd, int unsigned step);
        return $clog2(wd / step) + 1;
    endfunction

endpackage

// File: rtl/relm_div_step.sv
// One combinational restoring-division step: (P, S, d) -> (P', S').
module relm_div_step #(
    parameter int unsigned WD = 32
) (
    input  logic [WD-1:0] p_i,
    input  logic [WD-1:0] s_i,
    input  logic [WD-1:0] d_i,
    output logic [WD-1:0] p_o,
    output logic [WD-1:0] s_o
);

    logic [WD+1:0] diff;
    logic          q_bit;
    logic          unused_diff_top;

    // One extra guard bit so the borrow shows up in the MSB.
    always_comb begin
        diff  = {1'b0, p_i, s_i[WD-1]} - {2'b00, d_i};
        q_bit = ~diff[WD+1];
        p_o   = q_bit ? diff[WD-1:0] : {p_i[WD-2:0], s_i[WD-1]};
        s_o   = {s_i[WD-2:0], q_bit};
    end

    // With P < d the successful difference always fits in WD bits.
    assign unused_diff_top = diff[WD];

endmodule

// File: rtl/relm_div_seq.sv
// Self-timed restoring divider: integer and normalised-fraction modes, STEP quotient
// bits per cycle, results and flags registered on entry to DONE.
module relm_div_seq
    import relm_div_pkg::*;
#(
    parameter int unsigned WD   = 32,
    parameter int unsigned STEP = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_in,
    input  logic          mode_in,
    input  logic [WD-1:0] n_in,
    input  logic [WD-1:0] d_in,
    output logic          busy_out,
    output logic          done_out,
    output logic [WD-1:0] q_out,
    output logic [WD-1:0] r_out,
    output logic          sticky_out,
    output logic          dz_out
);

    localparam int unsigned ITER = iter_of(WD, STEP);
    localparam int unsigned CW   = cnt_width(WD, STEP);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WD-1:0] p_q, p_d;
    logic [WD-1:0] s_q, s_d;
    logic [WD-1:0] d_q, d_d;
    logic [WD-1:0] q_q, q_d;
    logic [WD-1:0] r_q, r_d;
    logic          sticky_q, sticky_d;
    logic          dz_q, dz_d;

    logic [WD-1:0] p_c [STEP+1];
    logic [WD-1:0] s_c [STEP+1];
    logic [WD-1:0] p_set, s_set;
    logic          div_zero;

    assign p_c[0] = p_q;
    assign s_c[0] = s_q;

    for (genvar i = 0; i < STEP; i++) begin : g_step
        relm_div_step #(
            .WD(WD)
        ) u_step (
            .p_i(p_c[i]),
            .s_i(s_c[i]),
            .d_i(d_q),
            .p_o(p_c[i+1]),
            .s_o(s_c[i+1])
        );
    end

    // Fraction mode divides n << (WD-1), so the upper word starts as n >> 1.
    always_comb begin
        if (mode_in == MODE_FRAC) begin
            p_set    = {1'b0, n_in[WD-1:1]};
            s_set    = {n_in[0], {(WD-1){1'b0}}};
            div_zero = ~d_in[WD-1];
        end else begin
            p_set    = '0;
            s_set    = n_in;
            div_zero = (d_in == '0);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        s_d      = s_q;
        d_d      = d_q;
        q_d      = q_q;
        r_d      = r_q;
        sticky_d = sticky_q;
        dz_d     = dz_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_in) begin
                    if (div_zero) begin
                        state_d  = StDone;
                        cnt_d    = '0;
                        q_d      = '1;
                        r_d      = n_in;
                        sticky_d = 1'b1;
                        dz_d     = 1'b1;
                    end else begin
                        state_d = StRun;
                        cnt_d   = CW'(ITER);
                        p_d     = p_set;
                        s_d     = s_set;
                        d_d     = d_in;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                p_d   = p_c[STEP];
                s_d   = s_c[STEP];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = StDone;
                    q_d      = s_c[STEP];
                    r_d      = p_c[STEP];
                    sticky_d = |p_c[STEP];
                    dz_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            p_q      <= '0;
            s_q      <= '0;
            d_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            s_q      <= s_d;
            d_q      <= d_d;
            q_q      <= q_d;
            r_q      <= r_d;
            sticky_q <= sticky_d;
            dz_q     <= dz_d;
        end
    end

    assign busy_out   = (state_q == StRun);
    assign done_out   = (state_q == StDone);
    assign q_out      = q_q;
    assign r_out      = r_q;
    assign sticky_out = sticky_q;
    assign dz_out     = dz_q;

endmodule

// File: tb/tb_relm_div_seq.sv
// Bench for relm_div_seq: three instances (STEP 2, 1, 4) checked every cycle against a
// timeline model built from plain 64-bit division.
module tb_relm_div_seq;

    function automatic int step_of(int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    endfunction

    function automatic int iter_of_k(int g);
        return 32 / step_of(g);
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a [3];
    logic        mode_a  [3];
    logic [31:0] n_a     [3];
    logic [31:0] d_a     [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic [31:0] q_a     [3];
    logic [31:0] r_a     [3];
    logic        st_a    [3];
    logic        dz_a    [3];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        relm_div_seq #(
            .WD(32),
            .STEP(step_of(g))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start_in  (start_a[g]),
            .mode_in   (mode_a[g]),
            .n_in      (n_a[g]),
            .d_in      (d_a[g]),
            .busy_out  (busy_a[g]),
            .done_out  (done_a[g]),
            .q_out     (q_a[g]),
            .r_out     (r_a[g]),
            .sticky_out(st_a[g]),
            .dz_out    (dz_a[g])
        );
    end

    // Reference: floor division of the 64-bit dividend, or the divide-by-zero result.
    function automatic void model(input logic mode, input logic [31:0] n, input logic [31:0] d,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic st, output logic dz);
        logic [63:0] dv;
        logic [63:0] qq;
        logic [63:0] rr;
        dz = mode ? ~d[31] : (d == 32'd0);
        if (dz) begin
            q  = 32'hFFFF_FFFF;
            r  = n;
            st = 1'b1;
        end else begin
            dv = mode ? ({32'd0, n} << 31) : {32'd0, n};
            qq = dv / {32'd0, d};
            rr = dv % {32'd0, d};
            q  = qq[31:0];
            r  = rr[31:0];
            st = (rr != 64'd0);
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Compare process: timeline model of each instance, checked every cycle.
    int          ecnt = 0;
    int          run_lo  [3];
    int          run_hi  [3];
    int          done_at [3];
    logic        pend_v  [3];
    logic [31:0] pend_q  [3];
    logic [31:0] pend_r  [3];
    logic        pend_st [3];
    logic        pend_dz [3];
    logic [31:0] cur_q   [3];
    logic [31:0] cur_r   [3];
    logic        cur_st  [3];
    logic        cur_dz  [3];

    always @(negedge clk) begin
        logic [31:0] mq, mr;
        logic        mst, mdz;
        logic        acc, ebusy, edone;
        ecnt++;
        if (ecnt == 1) begin
            model(1'b0, 32'd100, 32'd7, mq, mr, mst, mdz);
            chk("pin_int_100_7", {mq, mr}, {32'd14, 32'd2});
            model(1'b1, 32'h8000_0000, 32'hC000_0000, mq, mr, mst, mdz);
            chk("pin_frac_2_3", {mq, mr}, {32'h5555_5555, 32'h4000_0000});
            model(1'b1, 32'hC000_0000, 32'hC000_0000, mq, mr, mst, mdz);
            chk("pin_frac_eq", {mq, mr, 31'd0, mst}, {32'h8000_0000, 32'd0, 32'd0});
            model(1'b0, 32'd5, 32'd0, mq, mr, mst, mdz);
            chk("pin_dz", {mq, mr, 30'd0, mst, mdz}, {32'hFFFF_FFFF, 32'd5, 32'd3});
        end
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                run_lo[k]  = 1;
                run_hi[k]  = 0;
                done_at[k] = -1;
                pend_v[k]  = 1'b0;
                cur_q[k]   = '0;
                cur_r[k]   = '0;
                cur_st[k]  = 1'b0;
                cur_dz[k]  = 1'b0;
            end else begin
                if (ecnt == done_at[k] && pend_v[k]) begin
                    cur_q[k]  = pend_q[k];
                    cur_r[k]  = pend_r[k];
                    cur_st[k] = pend_st[k];
                    cur_dz[k] = pend_dz[k];
                    pend_v[k] = 1'b0;
                end
                acc = start_a[k] && !(run_lo[k] <= ecnt - 1 && ecnt - 1 <= run_hi[k]);
                if (acc) begin
                    model(mode_a[k], n_a[k], d_a[k], mq, mr, mst, mdz);
                    if (mdz) begin
                        cur_q[k]   = mq;
                        cur_r[k]   = mr;
                        cur_st[k]  = mst;
                        cur_dz[k]  = mdz;
                        run_lo[k]  = 1;
                        run_hi[k]  = 0;
                        done_at[k] = ecnt;
                    end else begin
                        pend_q[k]  = mq;
                        pend_r[k]  = mr;
                        pend_st[k] = mst;
                        pend_dz[k] = mdz;
                        pend_v[k]  = 1'b1;
                        run_lo[k]  = ecnt;
                        run_hi[k]  = ecnt + iter_of_k(k) - 1;
                        done_at[k] = ecnt + iter_of_k(k);
                    end
                end
            end
            ebusy = (run_lo[k] <= ecnt && ecnt <= run_hi[k]);
            edone = (ecnt == done_at[k]);
            chk($sformatf("busy[%0d]@%0d", k, ecnt), {63'd0, busy_a[k]}, {63'd0, ebusy});
            chk($sformatf("done[%0d]@%0d", k, ecnt), {63'd0, done_a[k]}, {63'd0, edone});
            chk($sformatf("q_r[%0d]@%0d", k, ecnt), {q_a[k], r_a[k]}, {cur_q[k], cur_r[k]});
            chk($sformatf("st_dz[%0d]@%0d", k, ecnt), {62'd0, st_a[k], dz_a[k]},
                {62'd0, cur_st[k], cur_dz[k]});
        end
    end

    // Stimulus is driven 1 time unit after the falling edge, away from the compare sample.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic op(input int k, input logic mode, input logic [31:0] n,
                      input logic [31:0] d, input bit b2b, input int inj, input int rstc);
        int  lat;
        logic dz;
        dz  = mode ? ~d[31] : (d == 32'd0);
        lat = dz ? 1 : iter_of_k(k) + 1;
        if (!b2b) tick();
        start_a[k] = 1'b1;
        mode_a[k]  = mode;
        n_a[k]     = n;
        d_a[k]     = d;
        for (int c = 1; c <= lat; c++) begin
            tick();
            start_a[k] = 1'b0;
            if (c == inj) begin
                start_a[k] = 1'b1;
                n_a[k]     = n ^ 32'h0000_1234;
                d_a[k]     = 32'd3;
            end
            if (c == rstc) begin
                reset      = 1'b1;
                start_a[k] = 1'b1;
            end
            if (rstc > 0 && c == rstc + 1) begin
                reset = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_a[k] = 1'b0;
            mode_a[k]  = 1'b0;
            n_a[k]     = '0;
            d_a[k]     = '0;
        end
        repeat (3) tick();
        reset = 1'b0;

        op(0, 1'b0, 32'd100, 32'd7, 1'b0, 0, 0);
        op(0, 1'b0, 32'd5, 32'd0, 1'b0, 0, 0);
        op(0, 1'b1, 32'd123, 32'h4000_0000, 1'b0, 0, 0);
        op(0, 1'b1, 32'h8000_0000, 32'hC000_0000, 1'b0, 0, 0);
        op(0, 1'b1, 32'hC000_0000, 32'hC000_0000, 1'b0, 0, 0);
        op(0, 1'b0, 32'd100, 32'd7, 1'b0, 3, 0);
        op(0, 1'b0, 32'd37, 32'd5, 1'b0, 0, 0);
        op(0, 1'b0, 32'd1000, 32'd3, 1'b1, 0, 0);
        op(0, 1'b0, 32'd5, 32'd0, 1'b1, 0, 0);
        op(0, 1'b0, 32'd999, 32'd10, 1'b1, 0, 0);
        op(0, 1'b0, 32'd77, 32'd9, 1'b0, 0, 5);
        op(0, 1'b0, 32'd100, 32'd7, 1'b0, 0, 0);
        op(1, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);
        op(2, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);
        op(2, 1'b1, 32'h8000_0000, 32'hC000_0000, 1'b1, 0, 0);
        op(1, 1'b1, 32'hC000_0000, 32'h8000_0001, 1'b0, 0, 0);

        for (int i = 0; i < 45; i++) begin
            int          k;
            logic        mode;
            logic [31:0] n, d;
            k    = i % 3;
            mode = 1'($urandom_range(0, 1));
            n    = $urandom;
            if (mode) d = ($urandom_range(0, 7) == 0) ? ($urandom >> 1) : ($urandom | 32'h8000_0000);
            else d = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            op(k, mode, n, d, bit'($urandom_range(0, 1)), 0, 0);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
